// File: rtl/amp_if_pkg.sv
// Shared types and constants for the amp-interface I2C target.
package amp_if_pkg;

    // Protocol states of the I2C target.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    localparam logic [6:0]  AMP_DEV_ADDR = 7'h20;
    localparam logic        I2C_ACK      = 1'b0;
    localparam logic        I2C_NACK     = 1'b1;
    localparam int unsigned SYNC_STAGES  = 2;

endpackage

// File: rtl/amp_i2c_slave_if.sv
// Bus/register-bank signal bundle for amp_i2c_slave.
interface amp_i2c_slave_if #(
    parameter int unsigned REG_AW = 7
) ();
    logic              scl_in;
    logic              sda_in;
    logic              sda_out;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [REG_AW-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;

    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_out, wr_en, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_out, wr_en, wr_addr, wr_data, rd_addr, busy
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises asynchronous scl/sda and detects edges, START and STOP.
module i2c_line_sync
    import amp_if_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Next values of the synchroniser chains and history stage.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
    end

    // Sync registers reset to the idle (released) bus level.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;
    assign start    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
endmodule

// File: rtl/amp_i2c_slave.sv
// I2C target: device/register-address writes become register-bank strobes.
// Define AMP_I2C_SLAVE_READ_EN to answer read (R/W=1) transfers.
module amp_i2c_slave
    import amp_if_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = AMP_DEV_ADDR,
    parameter int unsigned REG_AW   = 7
) (
    input  logic           clk_in,
    input  logic           reset,
    amp_i2c_slave_if.slave bus
);
    localparam logic [REG_AW-1:0] PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

`ifdef AMP_I2C_SLAVE_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
`endif

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_line_sync u_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .scl_in   (bus.scl_in),
        .sda_in   (bus.sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        tx_q, tx_d;
    logic [1:0]        ack_ph_q, ack_ph_d;
    logic              rd_mode_q, rd_mode_d;
    logic [REG_AW-1:0] pointer_q, pointer_d;
    logic              ptr_inc_q, ptr_inc_d;
    logic              sda_out_q, sda_out_d;
    logic              busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        byte_in;

    // Protocol FSM: bit shifting, ACK driving, write strobes and read shifting.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ack_ph_d  = ack_ph_q;
        rd_mode_d = rd_mode_q;
        pointer_d = pointer_q;
        ptr_inc_d = 1'b0;
        sda_out_d = sda_out_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        byte_in   = {shift_q, sda_s};

        if (ptr_inc_q) pointer_d = pointer_q + PTR_ONE;

        if (stop) begin
            state_d   = ST_IDLE;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start) begin
            // A driven ACK/data bit is released at the next scl_fall by DEV_ADDR.
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = '0;
            ack_ph_d  = '0;
        end else begin
            case (state_q)
                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                    if (scl_fall) sda_out_d = 1'b1;
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            ack_ph_d  = '0;
                            if (state_q == ST_DEV_ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR && (!byte_in[0] || READ_EN)) begin
                                    state_d   = ST_DEV_ACK;
                                    busy_d    = 1'b1;
                                    rd_mode_d = byte_in[0];
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_REG_ADDR) begin
                                pointer_d = byte_in[REG_AW-1:0];
                                state_d   = ST_REG_ACK;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = pointer_q;
                                wr_data_d = byte_in;
                                ptr_inc_d = 1'b1;
                                state_d   = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (ack_ph_q == 2'd0) begin
                            sda_out_d = I2C_ACK;
                            ack_ph_d  = 2'd1;
                        end else begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = '0;
                            if (state_q == ST_DEV_ACK && rd_mode_q) begin
                                state_d   = ST_RD_DATA;
                                tx_d      = {bus.rd_data[6:0], 1'b1};
                                sda_out_d = bus.rd_data[7];
                            end else if (state_q == ST_DEV_ACK) begin
                                state_d = ST_REG_ADDR;
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        sda_out_d = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b1};
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            ack_ph_d  = '0;
                            state_d   = ST_RD_ACK;
                        end
                    end
                end
                ST_RD_ACK: begin
                    // Phase 0 releases the line, 1 samples master ACK, 2 reloads on the fall.
                    if (ack_ph_q == 2'd0 && scl_fall) begin
                        sda_out_d = 1'b1;
                        ack_ph_d  = 2'd1;
                    end else if (ack_ph_q == 2'd1 && scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            ptr_inc_d = 1'b1;
                            ack_ph_d  = 2'd2;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (ack_ph_q == 2'd2 && scl_fall) begin
                        state_d   = ST_RD_DATA;
                        tx_d      = {bus.rd_data[6:0], 1'b1};
                        sda_out_d = bus.rd_data[7];
                    end
                end
                ST_IGNORE: begin
                    if (scl_fall) sda_out_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '1;
            ack_ph_q  <= '0;
            rd_mode_q <= 1'b0;
            pointer_q <= '0;
            ptr_inc_q <= 1'b0;
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ack_ph_q  <= ack_ph_d;
            rd_mode_q <= rd_mode_d;
            pointer_q <= pointer_d;
            ptr_inc_q <= ptr_inc_d;
            sda_out_q <= sda_out_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.sda_out = sda_out_q;
    assign bus.busy    = busy_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
`ifdef AMP_I2C_SLAVE_READ_EN
    assign bus.rd_addr = pointer_q;
`else
    assign bus.rd_addr = '0;
`endif
endmodule

// File: doc/amp_i2c_slave.md
Name: amp_i2c_slave

Overview:
- I2C target (responder) for the amp-interface I2C bus. It is the far end of the bootmem-driven config master.
- Receives device-address / register-address / data write transactions and emits one write strobe per data byte to a downstream register bank.
- Used in the amp model and the loopback bench, and as the on-chip config port of the amp-side logic.
- Sits between the synchronised sdai/scl pins and the register file.

Parameters:
- DEV_ADDR, 7'h20, 7-bit target address matched against the first byte after START.
- REG_AW, 7, register pointer width; the low REG_AW bits of the register-address byte are used.

Ports:
- clk_in  input  1  system clock; everything runs on its rising edge.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  I2C clock from the master, asynchronous.
- sda_in  input  1  I2C data from the bus, asynchronous.
- sda_out  output  1  open-drain data: 0 = pull low, 1 = release.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  REG_AW  register pointer for the write.
- wr_data  output  8  received data byte.
- rd_addr  output  REG_AW  pointer presented for reads (read feature only).
- rd_data  input  8  combinational read data for rd_addr (read feature only).
- busy  output  1  high from an addressed-match ACK until STOP.

Behaviour:
- Reset values: sda_out=1, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, pointer=0, state IDLE.
- Synchroniser: 2-FF sync on scl_in and sda_in, plus one history stage.
  - scl_rise / scl_fall / start / stop detected on synced values.
  - start = sda falls while scl high; stop = sda rises while scl high.
  - Input-to-detect latency is 3 clk_in cycles. scl high and low phases must each be at least 4 clk_in cycles.
- Sampling: data bits are sampled on scl_rise, MSB first. sda_out changes only on scl_fall.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE: wait for start, then go to DEV_ADDR with the bit counter cleared.
- DEV_ADDR:
  - After 8 bits, compare [7:1] to DEV_ADDR.
  - Match with R/W=0 → DEV_ACK, next REG_ADDR.
  - Match with R/W=1 → DEV_ACK, next RD_DATA (read feature only; otherwise treated as a mismatch).
  - Mismatch → IGNORE, sda_out stays 1.
- ACK states: drive sda_out=0 from the scl_fall after the 8th bit until the scl_fall after the 9th bit, then release. busy is set at the DEV_ACK entry.
- REG_ADDR: the 8th bit loads pointer = byte[REG_AW-1:0]. Then REG_ACK → WR_DATA.
- WR_DATA:
  - On the 8th scl_rise: wr_en=1 for exactly one cycle, wr_addr=pointer, wr_data=byte.
  - pointer increments in the following cycle, wrapping modulo 2^REG_AW.
  - Then WR_ACK → WR_DATA (burst write).
- start in any state (repeated start): release sda at the next scl_fall if driving, clear the bit counter, go to DEV_ADDR. pointer is kept.
- stop in any state: sda_out=1 immediately, busy=0, go to IDLE. A partial byte is discarded and gives no wr_en.
- IGNORE: never drives sda. Leave only on start or stop.
- Simultaneous start and scl edge cannot occur on the synced signals; start/stop take priority over bit sampling.
- reset mid-transaction: all outputs return to reset values in the next cycle and the bus is released. The block then waits for a fresh start; the ongoing transaction is ignored.

Optional Feature:
- AMP_I2C_SLAVE_READ_EN defined:
  - R/W=1 matches. rd_addr=pointer; rd_data is latched at the DEV_ACK→RD_DATA transition and shifted out MSB first, each bit driven on scl_fall.
  - RD_ACK samples the master's bit at the 9th scl_rise. Low (ACK): pointer+1, reload, continue. High (NACK): IGNORE until stop or start.
- Not defined:
  - R/W=1 is NACKed (→ IGNORE). rd_addr is tied to 0 and rd_data is unused.

Decomposition:
- Package amp_if_pkg:
  - state enum.
  - AMP_DEV_ADDR default 7'h20.
  - I2C_ACK=1'b0, I2C_NACK=1'b1.
  - SYNC_STAGES=2.
- Sub-module i2c_line_sync: 2-FF sync plus history, outputs scl_rise, scl_fall, start, stop, sda_s. It is reusable by the master-side bench monitor.

Test Plan:
- Write: START, 0x40 (addr 0x20,W), reg 0x40, data 0x18, STOP → three ACK lows on the 9th clocks; one wr_en with wr_addr=0x40, wr_data=0x18; busy falls at STOP.
- Burst: reg 0x35 then data 0x08, 0xAA, 0x55 → wr_en ×3 at addresses 0x35, 0x36, 0x37. Second case: reg 0x7F with two data bytes → addresses 0x7F, 0x00 (wrap).
- Mismatch: first byte 0x42 (addr 0x21) → sda_out stays 1 for the whole transaction; no wr_en; busy stays 0.
- Abort: STOP after 5 data bits → no wr_en; IDLE; sda released. Second case: reset asserted during DEV_ACK → sda_out=1 next cycle; the following clean write succeeds.
- Read with AMP_I2C_SLAVE_READ_EN: write reg 0x10, repeated START, 0x41, rd_data model = addr+1 → bytes 0x11, 0x12 with master ACK then NACK. Without the macro → 0x41 is NACKed.
- Timing: scl high/low = 10 clk_in cycles (div-5 master) and at the 4-cycle minimum → no missed bits; a 1-cycle sda_in glitch while scl is low → no false start/stop.
